div_core_nr: RTL and testbench
==============================

# div_core_nr

Iterative radix-2 non-restoring integer divider: the responder side of the ALU divide handshake (enable / sign_en / op1 / op2 in; rem_o / quo_o / ready / complete out). It accepts one signed or unsigned 32-bit divide when `ready` is high and returns quotient and remainder after a fixed WIDTH+2 cycles. It sits under the ALU, which holds the pipeline stalled while `ready` is low and captures results on `complete`.

## Interface
- WIDTH, 32, operand/result width; the iteration counter is clog2(WIDTH) bits.
- clk  in  1  clock; all state changes on its rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- enable  in  1  request; accepted when `enable & ready`.
- sign_en  in  1  1 = signed (two's complement), 0 = unsigned; sampled at accept.
- op1  in  WIDTH  dividend; sampled at accept.
- op2  in  WIDTH  divisor; sampled at accept.
- rem_o  out  WIDTH  remainder; registered; holds until the next completion.
- quo_o  out  WIDTH  quotient; registered; holds until the next completion.
- ready  out  1  idle, can accept; decoded from state.
- complete  out  1  one-cycle pulse; results valid this cycle.

## Operation
- States: IDLE, CALC, FIX, DONE. Reset forces IDLE.
- `ready` = (state == IDLE) | (state == DONE).
- IDLE/DONE -> CALC on accept. At accept, latch:
  - |op1| and |op2|: absolute values if sign_en, raw values otherwise.
  - Sign of the quotient: op1[MSB] ^ op2[MSB], gated by sign_en.
  - Sign of the remainder: op1[MSB], gated by sign_en.
  - A zero-divisor flag (op2 == 0).
  - Clear the counter and the partial remainder (WIDTH+1 bits, signed).
- CALC: one quotient bit per cycle for WIDTH cycles. Each cycle:
  - Shift the partial remainder left by one, bringing in the next dividend bit (MSB first).
  - If the partial remainder is >= 0, subtract |op2|; otherwise add |op2|.
  - The quotient bit is the inverse of the new partial remainder's sign.
- CALC -> FIX when the counter reaches WIDTH-1.
- FIX (1 cycle):
  - If the partial remainder is negative, add |op2| back.
  - Negate the quotient and/or the remainder per the latched signs.
  - Load quo_o/rem_o. State -> DONE.
- DONE (1 cycle): complete = 1. Next state is CALC on accept, else IDLE.
- Signed semantics: the quotient truncates toward zero; the remainder takes the dividend's sign; quo*op2 + rem == op1.
- Overflow, signed 0x80000000 / 0xFFFFFFFF: quo_o = 0x80000000, rem_o = 0. This falls out of the unsigned magnitude path and needs no special case.
- Divide by zero: quo_o = all ones, rem_o = op1 as latched, regardless of sign_en. The FIX stage forces these values; latency is unchanged.
- `enable` outside IDLE/DONE is ignored. op1/op2/sign_en may change freely after accept.
- The block does no dividend-zero or history short-circuit; the ALU handles those.

## Timing
- Reset values (asserted asynchronously, released synchronously through the state register):
  - state = IDLE, so ready = 1.
  - complete = 0, quo_o = 0, rem_o = 0; counter and datapath registers = 0.
- Accept at edge E0:
  - ready = 0 for the cycles after E0 through E0+WIDTH+1: WIDTH CALC cycles plus 1 FIX cycle (33 cycles for WIDTH=32).
  - DONE occupies the cycle after edge E0+WIDTH+1. In that cycle complete = 1, ready = 1, and quo_o/rem_o are valid.
  - Latency from accept to complete is WIDTH+2 edges.
- Back-to-back: an accept in the DONE cycle starts the next divide without an IDLE gap. complete still pulses exactly once per divide.
- Reset mid-operation: the state returns to IDLE immediately, ready = 1 immediately, outputs go to 0, and no complete is issued for the aborted divide.
- complete is never high for two consecutive cycles.

## Test plan
- Unsigned divide and timing check:
  - Stimulus: sign_en = 0, 100 / 7, enable pulsed in IDLE.
  - Response: ready low for exactly 33 cycles, then complete = 1 for one cycle with quo_o = 14 and rem_o = 2.
  - op1/op2 are randomized after accept with no effect on the result.
- Signed sign combinations, all with sign_en = 1:
  - -7 / 2 -> quo 0xFFFFFFFD, rem 0xFFFFFFFF.
  - 7 / -2 -> quo 0xFFFFFFFD, rem 1.
  - -7 / -2 -> quo 3, rem 0xFFFFFFFF.
- Boundary operands:
  - Signed 0x80000000 / 0xFFFFFFFF -> quo 0x80000000, rem 0.
  - Unsigned same operands -> quo 0, rem 0x80000000.
  - Unsigned 0xFFFFFFFF / 1 -> quo 0xFFFFFFFF, rem 0.
- Divide by zero: signed 0xFFFFFFF9 / 0 -> quo 0xFFFFFFFF, rem 0xFFFFFFF9, still after 34 edges.
- Back-to-back and hold:
  - Issue 100 / 7; assert enable with 50 / 6 during the DONE cycle.
  - Response: two complete pulses 34 cycles apart, the second with quo 8 and rem 2.
  - quo_o/rem_o hold 14/2 between the two pulses.
- Async reset: deassert rstn for half a cycle 10 cycles into a divide -> ready = 1 and outputs = 0 immediately, no complete pulse, and the next request completes correctly.

Source files
------------

// File: rtl/div_core_nr.sv
// Iterative radix-2 non-restoring divider, signed or unsigned, fixed WIDTH+2 cycle latency.
// The ALU drives the request side: enable, sign_en, op1 and op2.
module div_core_nr #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             sign_en,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o,
  output logic             ready,
  output logic             complete
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] divd_q, divd_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] qacc_q, qacc_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic             accept;
  logic [WIDTH:0]   dvsr_x;
  logic [WIDTH:0]   prem_sh;
  logic [WIDTH:0]   prem_nx;
  logic [WIDTH:0]   prem_fix;
  logic [WIDTH-1:0] rem_mag;

  assign ready    = (state_q == IDLE) || (state_q == DONE);
  assign complete = (state_q == DONE);
  assign accept   = enable & ready;
  assign quo_o    = quo_q;
  assign rem_o    = rem_q;

  // The partial remainder is kept mod 2^(WIDTH+1); its true value always
  // lies in [-|op2|, |op2|), so the truncated shift/add/sub stays exact.
  assign dvsr_x   = {1'b0, dvsr_q};
  assign prem_sh  = {prem_q[WIDTH-1:0], divd_q[WIDTH-1]};
  assign prem_nx  = prem_q[WIDTH] ? (prem_sh + dvsr_x) : (prem_sh - dvsr_x);
  assign prem_fix = prem_q[WIDTH] ? (prem_q + dvsr_x) : prem_q;
  assign rem_mag  = prem_fix[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    divd_d  = divd_q;
    dvsr_d  = dvsr_q;
    op1_d   = op1_q;
    qacc_d  = qacc_q;
    prem_d  = prem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          divd_d  = (sign_en & op1[WIDTH-1]) ? -op1 : op1;
          dvsr_d  = (sign_en & op2[WIDTH-1]) ? -op2 : op2;
          op1_d   = op1;
          qneg_d  = sign_en & (op1[WIDTH-1] ^ op2[WIDTH-1]);
          rneg_d  = sign_en & op1[WIDTH-1];
          dz_d    = (op2 == '0);
          cnt_d   = '0;
          prem_d  = '0;
          qacc_d  = '0;
          state_d = CALC;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        prem_d = prem_nx;
        qacc_d = {qacc_q[WIDTH-2:0], ~prem_nx[WIDTH]};
        divd_d = {divd_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        if (dz_q) begin
          quo_d = '1;
          rem_d = op1_q;
        end else begin
          quo_d = qneg_q ? -qacc_q : qacc_q;
          rem_d = rneg_q ? -rem_mag : rem_mag;
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      divd_q  <= '0;
      dvsr_q  <= '0;
      op1_q   <= '0;
      qacc_q  <= '0;
      prem_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      divd_q  <= divd_d;
      dvsr_q  <= dvsr_d;
      op1_q   <= op1_d;
      qacc_q  <= qacc_d;
      prem_q  <= prem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_div_core_nr.sv
// Directed bench for div_core_nr: vector table plus back-to-back and async-reset sequences.
module tb_div_core_nr;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rstn;
  logic         enable;
  logic         sign_en;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic [W-1:0] rem_o;
  logic [W-1:0] quo_o;
  logic         ready;
  logic         complete;

  int unsigned n_checks;
  int unsigned n_fail;

  div_core_nr #(.WIDTH(W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .enable   (enable),
    .sign_en  (sign_en),
    .op1      (op1),
    .op2      (op2),
    .rem_o    (rem_o),
    .quo_o    (quo_o),
    .ready    (ready),
    .complete (complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Called on a negedge with the core ready; returns on the negedge after the complete cycle.
  task automatic run_div(input string nm, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eq, input logic [W-1:0] er);
    int unsigned lowc;
    check({nm, " ready_before"}, W'(ready), W'(1));
    sign_en = s; op1 = a; op2 = b; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0; op1 = $urandom; op2 = $urandom; sign_en = 1'($urandom_range(0, 1));
    lowc = 0;
    while (!ready && lowc < 100) begin
      lowc++;
      @(negedge clk);
    end
    check({nm, " ready_low_cycles"}, W'(lowc), W'(33));
    check({nm, " complete"}, W'(complete), W'(1));
    check({nm, " quo"}, quo_o, eq);
    check({nm, " rem"}, rem_o, er);
    @(negedge clk);
    check({nm, " complete_single"}, W'(complete), W'(0));
  endtask

  vec_t vecs[$];

  initial begin
    int unsigned t1;
    int unsigned gap;
    int unsigned pulses;
    n_checks = 0;
    n_fail   = 0;
    enable = 1'b0; sign_en = 1'b0; op1 = '0; op2 = '0;

    vecs.push_back('{"u100_7",     1'b0, 32'd100,        32'd7,          32'd14,         32'd2});
    vecs.push_back('{"sm7_2",      1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF});
    vecs.push_back('{"s7_m2",      1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1});
    vecs.push_back('{"sm7_m2",     1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF});
    vecs.push_back('{"s_ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0});
    vecs.push_back('{"u_ovf_ops",  1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000});
    vecs.push_back('{"u_max_1",    1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0});
    vecs.push_back('{"s_divzero",  1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9});
    vecs.push_back('{"u_divzero",  1'b0, 32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234});
    vecs.push_back('{"u_big",      1'b0, 32'hDEAD_BEEF,  32'd1000,       32'd3735928,    32'd559});

    rstn = 1'b0;
    #2;
    check("reset ready", W'(ready), W'(1));
    check("reset complete", W'(complete), W'(0));
    check("reset quo", quo_o, '0);
    check("reset rem", rem_o, '0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++)
      run_div(vecs[i].name, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);

    // Back-to-back: second request accepted in the DONE cycle of the first.
    sign_en = 1'b0; op1 = 32'd100; op2 = 32'd7; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    t1 = 0;
    while (!complete && t1 < 100) begin
      t1++;
      @(negedge clk);
    end
    check("b2b first complete", W'(complete), W'(1));
    check("b2b first quo", quo_o, 32'd14);
    sign_en = 1'b0; op1 = 32'd50; op2 = 32'd6; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0; op1 = $urandom; op2 = $urandom;
    check("b2b accepted", W'(ready), W'(0));
    gap = 1;
    pulses = 0;
    while (!complete && gap < 100) begin
      if (quo_o !== 32'd14 || rem_o !== 32'd2) pulses++;
      gap++;
      @(negedge clk);
    end
    check("b2b hold", W'(pulses), W'(0));
    check("b2b gap", W'(gap), W'(34));
    check("b2b second quo", quo_o, 32'd8);
    check("b2b second rem", rem_o, 32'd2);
    @(negedge clk);
    check("b2b complete_single", W'(complete), W'(0));

    // Async reset mid-divide: outputs currently hold 8/2.
    sign_en = 1'b0; op1 = 32'd1000; op2 = 32'd3; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("arst ready", W'(ready), W'(1));
    check("arst quo", quo_o, '0);
    check("arst rem", rem_o, '0);
    check("arst complete", W'(complete), W'(0));
    #2;
    rstn = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (complete) pulses++;
    end
    check("arst no_complete", W'(pulses), W'(0));
    run_div("after_reset", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
